// File: rtl/hbm_rd_engine.sv
// AXI read traffic generator: issues a programmed run of INCR bursts at a fixed stride
// and collects beat, error, latency and run-time statistics for the host.
module hbm_rd_engine #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MAX_OUTST  = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  num_bursts,
  input  logic [7:0]            burst_len,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [ID_WIDTH-1:0]   arid,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  total_cycles,
  output logic [CNT_WIDTH-1:0]  first_lat,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);
  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);
  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic [OUTST_W-1:0]    outst_q, outst_d;
  logic [7:0]            bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [CNT_WIDTH-1:0]  lat_q, lat_d;
  logic                  lat_run_q, lat_run_d;
  logic                  lat_done_q, lat_done_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rready_q, rready_d;

  logic ar_hs_c, r_hs_c, rlast_hs_c, beat_bad_c;
  logic unused_inputs_c;

  assign ar_hs_c    = arvalid_q & arready;
  assign r_hs_c     = rvalid & rready_q;
  assign rlast_hs_c = r_hs_c & rlast;
  // One error per beat: bad response, or rlast disagreeing with the expected burst position
  assign beat_bad_c = (rresp != 2'b00) | (rlast != (bcnt_q == arlen_q));
  assign unused_inputs_c = ^{rdata, rid};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    num_d      = num_q;
    stride_d   = stride_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    outst_d    = outst_q;
    bcnt_d     = bcnt_q;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    total_d    = total_q;
    lat_d      = lat_q;
    lat_run_d  = lat_run_q;
    lat_done_d = lat_done_q;
    arvalid_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rready_d   = 1'b0;

    if (state_q == S_RUN || state_q == S_DRAIN) total_d = sat_inc(total_q);

    if (ar_hs_c && !rlast_hs_c) outst_d = outst_q + OUTST_W'(1);
    else if (!ar_hs_c && rlast_hs_c && outst_q != '0) outst_d = outst_q - OUTST_W'(1);

    if (r_hs_c) begin
      beat_cnt_d = sat_inc(beat_cnt_q);
      if (beat_bad_c) err_cnt_d = sat_inc(err_cnt_q);
      bcnt_d = rlast ? 8'd0 : bcnt_q + 8'd1;
    end

    // Latency counter runs from the cycle after the first AR handshake up to the first R handshake
    if (lat_run_q && !lat_done_q) begin
      lat_d = sat_inc(lat_q);
      if (r_hs_c) lat_done_d = 1'b1;
    end
    if (ar_hs_c) lat_run_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d      = num_bursts;
          stride_d   = stride;
          araddr_d   = base_addr;
          arlen_d    = burst_len;
          issued_d   = '0;
          outst_d    = '0;
          bcnt_d     = '0;
          beat_cnt_d = '0;
          err_cnt_d  = '0;
          total_d    = '0;
          lat_d      = '0;
          lat_run_d  = 1'b0;
          lat_done_d = 1'b0;
          state_d    = (num_bursts == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (ar_hs_c) begin
          issued_d = issued_q + CNT_WIDTH'(1);
          araddr_d = araddr_q + stride_q;
          if (issued_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered valid; while stalled issued and outst cannot move against it, so it holds
    arvalid_d = (state_d == S_RUN) && (issued_d < num_d) && (outst_d < OUTST_MAX);
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    rready_d  = busy_d;
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      num_q      <= '0;
      stride_q   <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      outst_q    <= '0;
      bcnt_q     <= '0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      total_q    <= '0;
      lat_q      <= '0;
      lat_run_q  <= 1'b0;
      lat_done_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      num_q      <= num_d;
      stride_q   <= stride_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      outst_q    <= outst_d;
      bcnt_q     <= bcnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      total_q    <= total_d;
      lat_q      <= lat_d;
      lat_run_q  <= lat_run_d;
      lat_done_q <= lat_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rready_q   <= rready_d;
    end
  end

  assign araddr       = araddr_q;
  assign arlen        = arlen_q;
  assign arsize       = ARSIZE;
  assign arburst      = 2'b01;
  assign arid         = '0;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign total_cycles = total_q;
  assign first_lat    = lat_q;
  assign beat_cnt     = beat_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_hbm_rd_engine.sv
// Directed + randomized bench for hbm_rd_engine with an AXI slave model and a
// burst-level reference of addresses, beats, errors, latency and run length.
module tb_hbm_rd_engine;

  localparam int unsigned AW = 33;
  localparam int unsigned DW = 512;
  localparam int unsigned IW = 1;
  localparam int unsigned CW = 32;
  localparam int unsigned MO = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          start;
  logic [AW-1:0] base_addr, stride;
  logic [CW-1:0] num_bursts;
  logic [7:0]    burst_len;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;
  logic          rvalid, rready;
  logic          busy, done;
  logic [CW-1:0] total_cycles, first_lat, beat_cnt, err_cnt;

  always #5 clk = ~clk;

  hbm_rd_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr), .stride(stride),
    .num_bursts(num_bursts), .burst_len(burst_len), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .total_cycles(total_cycles), .first_lat(first_lat),
    .beat_cnt(beat_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [1:0] resp;
    logic       last;
    int         idx;
    int         rdy;
  } beat_t;

  beat_t         rq[$];
  logic [AW-1:0] ar_log[$];

  logic [AW-1:0] m_base, m_stride;
  int            m_num, m_len;
  int            issued_m, outst_m, beats_m, err_m;
  int            first_ar, first_r, last_r, start_edge, cyc;

  int  ar_lo_cnt, r_dly_max;
  bit  ar_rand, r_hold, r_gap, r_rand_err, inj_err;

  logic          p_arvalid, p_rready;
  logic [AW-1:0] p_araddr;
  logic [7:0]    p_arlen;

  int n_chk, n_pass, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave plans the full R response of a burst when its AR is accepted
  task automatic plan_burst(input int e);
    int nb, dly;
    beat_t b;
    nb  = m_len + 1;
    dly = $urandom_range(r_dly_max);
    if (inj_err && issued_m == 0) nb = m_len;
    for (int j = 0; j < nb; j++) begin
      b.resp = 2'b00;
      if (inj_err && issued_m == 0 && j == 0) b.resp = 2'b10;
      else if (r_rand_err && $urandom_range(7) == 0) b.resp = 2'($urandom_range(3, 1));
      b.last = (j == nb - 1);
      b.idx  = j;
      b.rdy  = e + 1 + dly;
      rq.push_back(b);
    end
  endtask

  // One clock: account for the handshakes of the edge just passed, check, drive next inputs
  task automatic step();
    beat_t b;
    logic [AW-1:0] ea;
    @(negedge clk);
    cyc++;
    if (p_arvalid && arready) begin
      ea = m_base + m_stride * AW'(issued_m);
      chk("ar_addr", 64'(p_araddr), 64'(ea));
      chk("ar_len", 64'(p_arlen), 64'(m_len));
      ar_log.push_back(p_araddr);
      if (issued_m == 0) first_ar = cyc;
      plan_burst(cyc);
      issued_m++;
      outst_m++;
    end else if (p_arvalid) begin
      chk("ar_hold_valid", 64'(arvalid), 64'd1);
      chk("ar_hold_addr", 64'(araddr), 64'(p_araddr));
      chk("ar_hold_len", 64'(arlen), 64'(p_arlen));
    end
    if (rvalid && p_rready) begin
      b = rq.pop_front();
      beats_m++;
      if (b.resp != 2'b00 || (b.last != (b.idx == m_len))) err_m++;
      if (first_r < 0) first_r = cyc;
      if (b.last) begin
        outst_m--;
        last_r = cyc;
      end
    end
    if (arvalid) begin
      chk("ar_outst_limit", 64'(outst_m < int'(MO)), 64'd1);
      chk("ar_excess", 64'(issued_m < m_num), 64'd1);
    end
    if (ar_lo_cnt > 0) begin
      arready = 1'b0;
      ar_lo_cnt--;
    end else begin
      arready = ar_rand ? 1'($urandom_range(1)) : 1'b1;
    end
    if (rvalid && !p_rready) begin
      rvalid = 1'b1;
    end else if (!r_hold && rq.size() > 0 && rq[0].rdy <= cyc + 1 &&
                 (!r_gap || $urandom_range(3) != 0)) begin
      rvalid = 1'b1;
      rresp  = rq[0].resp;
      rlast  = rq[0].last;
      rdata  = {16{$urandom()}};
    end else begin
      rvalid = 1'b0;
      rresp  = 2'b00;
      rlast  = 1'b0;
    end
    p_arvalid = arvalid;
    p_araddr  = araddr;
    p_arlen   = arlen;
    p_rready  = rready;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    start = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    rq.delete();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    p_arvalid = 1'b0;
    p_rready = 1'b0;
    p_araddr = '0;
    p_arlen = '0;
  endtask

  task automatic begin_run(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n, input int l);
    m_base = b; m_stride = s; m_num = n; m_len = l;
    issued_m = 0; outst_m = 0; beats_m = 0; err_m = 0;
    first_ar = -1; first_r = -1; last_r = -1;
    ar_log.delete();
    base_addr = b; stride = s; num_bursts = CW'(n); burst_len = 8'(l);
    start = 1'b1;
    step();
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic finish_run();
    int k;
    k = 0;
    while (!done && k < 5000) begin
      step();
      k++;
    end
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_issued", 64'(issued_m), 64'(m_num));
    chk("run_outst", 64'(outst_m), 64'd0);
    chk("run_rq_empty", 64'(rq.size()), 64'd0);
    chk("run_beat_cnt", 64'(beat_cnt), 64'(beats_m));
    chk("run_err_cnt", 64'(err_cnt), 64'(err_m));
    chk("run_first_lat", 64'(first_lat), 64'(first_r - first_ar));
    chk("run_total", 64'(total_cycles), 64'(last_r - start_edge));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
    ar_lo_cnt = 0; r_dly_max = 0;
    ar_rand = 0; r_hold = 0; r_gap = 0; r_rand_err = 0; inj_err = 0;
    base_addr = '0; stride = '0; num_bursts = '0; burst_len = '0;
    rdata = '0; rid = '0;
    m_num = 0; m_len = 0; issued_m = 0; outst_m = 0;
    do_reset();

    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("rst_arsize", 64'(arsize), 64'd6);
    chk("rst_arburst", 64'(arburst), 64'd1);
    chk("rst_arid", 64'(arid), 64'd0);
    chk("rst_counters", 64'({beat_cnt, err_cnt} | {total_cycles, first_lat}), 64'd0);

    // Basic run with an always-ready, single-cycle-latency slave
    begin_run(33'h0, 33'h40, 4, 0);
    finish_run();
    chk("basic_addr3", 64'(ar_log[3]), 64'hC0);
    chk("basic_beats", 64'(beat_cnt), 64'd4);
    chk("basic_err", 64'(err_cnt), 64'd0);
    chk("basic_lat", 64'(first_lat), 64'd1);

    // AR backpressure for 5 cycles mid-run
    begin_run(33'h1000, 33'h100, 12, 0);
    repeat (4) step();
    chk("bp_arvalid", 64'(arvalid), 64'd1);
    ar_lo_cnt = 5;
    finish_run();
    chk("bp_beats", 64'(beat_cnt), 64'd12);

    // Outstanding limit with R data withheld
    r_hold = 1;
    begin_run(33'h2000, 33'h40, 8, 1);
    repeat (12) step();
    chk("outst_issued", 64'(issued_m), 64'(MO));
    chk("outst_arvalid", 64'(arvalid), 64'd0);
    r_hold = 0;
    finish_run();
    chk("outst_beats", 64'(beat_cnt), 64'd16);

    // Address wrap at the top of the 8 GB space
    begin_run(33'h1_FFFF_FFC0, 33'h40, 2, 0);
    finish_run();
    chk("wrap_addr0", 64'(ar_log[0]), 64'h1_FFFF_FFC0);
    chk("wrap_addr1", 64'(ar_log[1]), 64'h0);

    // Short first burst with an error response on another beat
    inj_err = 1;
    begin_run(33'h3000, 33'h40, 3, 3);
    finish_run();
    chk("err_inject", 64'(err_cnt), 64'd2);
    inj_err = 0;

    // Zero-length run
    begin_run(33'h5000, 33'h40, 0, 0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_arvalid", 64'(arvalid), 64'd0);
    repeat (3) step();
    chk("zero_total", 64'(total_cycles), 64'd0);

    // start while busy must be ignored
    begin_run(33'h6000, 33'h80, 10, 1);
    repeat (3) step();
    base_addr = 33'h7777;
    num_bursts = CW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_run();

    // Randomized runs
    ar_rand = 1; r_gap = 1; r_rand_err = 1;
    for (int i = 0; i < 6; i++) begin
      r_dly_max = $urandom_range(6);
      begin_run(AW'({$urandom(), $urandom()}), AW'({$urandom(), $urandom()}),
                int'($urandom_range(20, 1)), int'($urandom_range(7)));
      finish_run();
    end
    ar_rand = 0; r_gap = 0; r_rand_err = 0; r_dly_max = 0;

    // Asynchronous reset in the middle of a run
    r_hold = 1;
    begin_run(33'h9000, 33'h40, 6, 0);
    repeat (5) step();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    arst = 1'b1;
    #1;
    chk("arst_arvalid", 64'(arvalid), 64'd0);
    chk("arst_rready", 64'(rready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_araddr", 64'(araddr), 64'd0);
    chk("arst_counters", 64'({beat_cnt, err_cnt} | {total_cycles, first_lat}), 64'd0);
    r_hold = 0;
    do_reset();
    begin_run(33'hA000, 33'h40, 3, 2);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
